// File: rtl/ad7946_pkg.sv
// ad7946_pkg
// Shared types and helpers for the AD7946 sample streaming path.
//   AD7946_WORD_W  : width of a raw conversion word from the serial controller
//   stream_state_t : capture state machine encoding
//   extract_sample : pulls the valid MSBs out of a raw word, right-justified
package ad7946_pkg;

    localparam int AD7946_WORD_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN
    } stream_state_t;

    // The converter delivers its result MSB first, so the sample occupies the
    // top sample_w bits; a logical right shift both justifies and zero-extends.
    function automatic logic [AD7946_WORD_W-1:0] extract_sample(
        input logic [AD7946_WORD_W-1:0] word,
        input int                       sample_w
    );
        return word >> (AD7946_WORD_W - sample_w);
    endfunction

endpackage

// File: rtl/ad7946_sample_stream_if.sv
// ad7946_sample_stream_if
// AXI4-Stream bundle carrying the framed sample stream.
//   tdata  : 16-bit sample beat
//   tvalid : beat valid (master -> slave)
//   tready : beat accepted (slave -> master)
//   tlast  : final beat of a packet
interface ad7946_sample_stream_if;

    logic [15:0] tdata;
    logic        tvalid;
    logic        tready;
    logic        tlast;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);

endinterface

// File: rtl/ad7946_sample_stream_fifo.sv
// sync_fifo_fwft
// Single-clock first-word-fall-through FIFO on a distributed-RAM array.
//   clk, resetn    : clock and asynchronous active-low reset
//   wr_en, wr_data : write request and data (ignored while full)
//   rd_en          : pop the head entry (ignored while empty)
//   rd_data        : head entry, read asynchronously
//   level          : registered occupancy
//   full, empty    : decoded from the registered level
module sync_fifo_fwft #(
    parameter  int WIDTH = 16,
    parameter  int DEPTH = 16,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int LVL_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic [LVL_W-1:0] level,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             wr_ok, rd_ok;

    assign full  = (level_q == LVL_W'(DEPTH));
    assign empty = (level_q == '0);
    assign wr_ok = wr_en & ~full;
    assign rd_ok = rd_en & ~empty;

    // DEPTH is a power of two, so the pointers wrap by plain overflow.
    always_comb begin
        wr_ptr_d = wr_ptr_q + PTR_W'(wr_ok);
        rd_ptr_d = rd_ptr_q + PTR_W'(rd_ok);
        level_d  = level_q + LVL_W'(wr_ok) - LVL_W'(rd_ok);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage carries no reset so it maps onto LUT RAM.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

    assign rd_data = mem[rd_ptr_q];
    assign level   = level_q;

endmodule

// File: rtl/ad7946_sample_stream.sv
// ad7946_sample_stream
// Buffers AD7946 conversion words and emits them as fixed-length AXI4-Stream
// packets, counting samples dropped when the FIFO is full.
//   clk, resetn    : 100 MHz AXI clock, asynchronous active-low reset
//   enable         : capture enable
//   in_valid       : one-cycle strobe, in_data/in_chsel hold a new word
//   m_axis         : AXI4-Stream master (tdata/tvalid/tready/tlast)
//   overflow_clr   : one-cycle clear of overflow_count
//   overflow_count : saturating dropped-sample count
//   fifo_level     : current FIFO occupancy
// Build option AD7946_SAMPLE_STREAM_CHTAG_EN: when defined, tdata[15] carries
// the channel select captured with each sample.
module ad7946_sample_stream
    import ad7946_pkg::*;
#(
    parameter  int DEPTH     = 16,
    parameter  int FRAME_LEN = 64,
    parameter  int SAMPLE_W  = 14,
    localparam int LVL_W     = $clog2(DEPTH) + 1,
    localparam int BEAT_W    = $clog2(FRAME_LEN)
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     enable,
    input  logic                     in_valid,
    input  logic [AD7946_WORD_W-1:0] in_data,
    input  logic                     in_chsel,
    ad7946_sample_stream_if.master   m_axis,
    input  logic                     overflow_clr,
    output logic [15:0]              overflow_count,
    output logic [LVL_W-1:0]         fifo_level
);

    stream_state_t            state_q, state_d;
    logic [BEAT_W-1:0]        beat_q, beat_d;
    logic [15:0]              ovf_q, ovf_d;
    logic [AD7946_WORD_W-1:0] sample;
    logic [AD7946_WORD_W-1:0] out_word;
    logic                     fifo_full, fifo_empty;
    logic                     wr_en, drop, handshake, tvalid;
    logic                     beat_last;

    assign sample = extract_sample(in_data, SAMPLE_W);

`ifdef AD7946_SAMPLE_STREAM_CHTAG_EN
    localparam int FIFO_W = AD7946_WORD_W + 1;

    if (SAMPLE_W > 15) begin : g_sample_w_check
        $error("SAMPLE_W must be <= 15 when the channel tag is enabled");
    end

    logic [FIFO_W-1:0] wr_data, rd_data;
    logic              unused_rd_msb;

    // Tag sits above a full 16-bit sample; bit 15 of the sample is always zero
    // here and is replaced by the tag on the way out.
    assign wr_data       = {in_chsel, sample};
    assign out_word      = {rd_data[16], rd_data[14:0]};
    assign unused_rd_msb = rd_data[15];
`else
    localparam int FIFO_W = AD7946_WORD_W;

    logic [FIFO_W-1:0] wr_data, rd_data;
    logic              unused_chsel;

    assign wr_data      = sample;
    assign out_word     = rd_data;
    assign unused_chsel = in_chsel;
`endif

    // Fullness is judged on the registered level, so a read in the same cycle
    // does not make room for a write.
    assign wr_en     = in_valid & (state_q == ST_RUN) & ~fifo_full;
    assign drop      = in_valid & (state_q == ST_RUN) & fifo_full;
    assign tvalid    = ~fifo_empty;
    assign handshake = tvalid & m_axis.tready;
    assign beat_last = (beat_q == BEAT_W'(FRAME_LEN - 1));

    sync_fifo_fwft #(
        .WIDTH (FIFO_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .resetn  (resetn),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .rd_en   (handshake),
        .rd_data (rd_data),
        .level   (fifo_level),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Next-state for the capture FSM, beat counter and overflow counter.
    // DRAIN only reaches IDLE once empty, so no handshake can coincide with
    // the beat counter being cleared on entry to IDLE.
    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        ovf_d   = ovf_q;

        unique case (state_q)
            ST_IDLE:  if (enable) state_d = ST_RUN;
            ST_RUN:   if (!enable) state_d = ST_DRAIN;
            ST_DRAIN: begin
                if (enable) begin
                    state_d = ST_RUN;
                end else if (fifo_empty) begin
                    state_d = ST_IDLE;
                end
            end
            default:  state_d = ST_IDLE;
        endcase

        if (handshake) begin
            beat_d = beat_last ? '0 : beat_q + BEAT_W'(1);
        end
        if (state_d == ST_IDLE && state_q != ST_IDLE) begin
            beat_d = '0;
        end

        if (overflow_clr) begin
            ovf_d = drop ? 16'd1 : 16'd0;
        end else if (drop && ovf_q != 16'hFFFF) begin
            ovf_d = ovf_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            beat_q  <= '0;
            ovf_q   <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            ovf_q   <= ovf_d;
        end
    end

    // Data is masked while not valid so the bus reads zero out of reset.
    assign m_axis.tvalid  = tvalid;
    assign m_axis.tdata   = tvalid ? out_word : 16'h0000;
    assign m_axis.tlast   = tvalid & beat_last;
    assign overflow_count = ovf_q;

endmodule
